// File: rtl/zeroriscy_bnn_seq_if.sv
// Bundle of signals between the zeroriscy_bnn_seq command initiator and its
// surroundings: the estimate unit op channel and the activation read port.
// Ports (master = sequencer): bnn_en/operator/addr/data out, bnn_ready/result in,
//   act_addr out, act_rdata in (synchronous memory, 1-cycle read latency).
interface zeroriscy_bnn_seq_if #(
   parameter int ADDR_W = 32
);
   logic              bnn_en;
   logic [2:0]        bnn_operator;
   logic [ADDR_W-1:0] bnn_addr;
   logic [31:0]       bnn_data;
   logic              bnn_ready;
   logic [31:0]       bnn_result;
   logic [ADDR_W-1:0] act_addr;
   logic [31:0]       act_rdata;

   modport master (
      output bnn_en, bnn_operator, bnn_addr, bnn_data, act_addr,
      input  bnn_ready, bnn_result, act_rdata
   );

   modport slave (
      input  bnn_en, bnn_operator, bnn_addr, bnn_data, act_addr,
      output bnn_ready, bnn_result, act_rdata
   );
endinterface

// File: rtl/zeroriscy_bnn_seq.sv
// Command initiator for the zeroriscy_bnn estimate unit: for one output-neuron
// group it issues ini, N acc ops per pooling window (activation words fetched from
// a synchronous memory), a pool op per window, a norm op, then captures the result.
// Latency: done_o in cycle 1 + W*(N+2) + 1 + 3 + 1 counted from the start edge
//   (the INI cycle is cycle 1); an N=0 window costs 2 cycles.
// Backpressure: with bnn_ready low no op is issued and state, counters and
//   act_addr hold; the op is reissued when ready returns. DRAIN also pauses.
// Ports: clk, rst_n (async active-low); start_i and config inputs latched at the
//   accepted start; bus (master modport) carries the op channel and activation
//   port; busy_o, done_o (1-cycle pulse) and result_o report status to the core.
module zeroriscy_bnn_seq #(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [CNT_W-1:0]    in_words_i,
   input  logic [CNT_W-1:0]    pool_win_i,
   input  logic [ADDR_W-1:0]   param_base_i,
   input  logic [ADDR_W-1:0]   norm_addr_i,
   input  logic [ADDR_W-1:0]   act_base_i,
   input  logic [15:0]         bias_i,
   zeroriscy_bnn_seq_if.master bus,
   output logic                busy_o,
   output logic                done_o,
   output logic [31:0]         result_o
);

   localparam logic [2:0] OP_INI  = 3'd0;
   localparam logic [2:0] OP_ACC  = 3'd1;
   localparam logic [2:0] OP_POOL = 3'd2;
   localparam logic [2:0] OP_NORM = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INI,
      S_PREF,
      S_ACC,
      S_POOL,
      S_NORM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state;

   // Latched configuration
   logic [CNT_W-1:0]  n_words;
   logic [CNT_W-1:0]  w_lim;
   logic [ADDR_W-1:0] param_base;
   logic [ADDR_W-1:0] norm_addr;
   logic [15:0]       bias_q;

   // Sequencing counters and the running activation pointer
   logic [CNT_W-1:0]  k_cnt;
   logic [CNT_W-1:0]  w_cnt;
   logic [1:0]        drain_cnt;
   logic [ADDR_W-1:0] act_ptr;

   // Pending op, registered when the state that issues it is entered
   logic              op_vld;
   logic [2:0]        op_code;
   logic [ADDR_W-1:0] op_addr;
   logic [31:0]       op_dat;
   logic              op_from_act;

   // While an acc op is stalled the held address already points at the next
   // word, so the memory output moves on; the word owed to the stalled op is
   // parked here on the first stall cycle and used when the op reissues.
   logic [31:0]       hold_dat;
   logic              hold_vld;

   logic              fire;
   logic [CNT_W-1:0]  k_inc;
   logic [CNT_W-1:0]  w_inc;
   logic [CNT_W-1:0]  n_last;
   logic [31:0]       acc_dat;

   assign fire    = op_vld & bus.bnn_ready;
   assign k_inc   = k_cnt + CNT_W'(1);
   assign w_inc   = w_cnt + CNT_W'(1);
   assign n_last  = n_words - CNT_W'(1);
   assign acc_dat = hold_vld ? hold_dat : bus.act_rdata;

   assign bus.bnn_en       = fire;
   assign bus.bnn_operator = fire ? op_code : 3'd0;
   assign bus.bnn_addr     = fire ? op_addr : '0;
   assign bus.bnn_data     = !fire ? 32'h0 : (op_from_act ? acc_dat : op_dat);
   assign bus.act_addr     = act_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         n_words     <= '0;
         w_lim       <= '0;
         param_base  <= '0;
         norm_addr   <= '0;
         bias_q      <= '0;
         k_cnt       <= '0;
         w_cnt       <= '0;
         drain_cnt   <= '0;
         act_ptr     <= '0;
         op_vld      <= 1'b0;
         op_code     <= OP_INI;
         op_addr     <= '0;
         op_dat      <= '0;
         op_from_act <= 1'b0;
         hold_dat    <= '0;
         hold_vld    <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         result_o    <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  n_words     <= in_words_i;
                  w_lim       <= (pool_win_i == '0) ? CNT_W'(1) : pool_win_i;
                  param_base  <= param_base_i;
                  norm_addr   <= norm_addr_i;
                  bias_q      <= bias_i;
                  act_ptr     <= act_base_i;
                  k_cnt       <= '0;
                  w_cnt       <= '0;
                  drain_cnt   <= '0;
                  hold_vld    <= 1'b0;
                  busy_o      <= 1'b1;
                  op_vld      <= 1'b1;
                  op_code     <= OP_INI;
                  op_addr     <= '0;
                  op_dat      <= {16'h0, bias_i};
                  op_from_act <= 1'b0;
                  state       <= S_INI;
               end
            end

            S_INI: begin
               if (bus.bnn_ready) begin
                  op_vld <= 1'b0;
                  state  <= S_PREF;
               end
            end

            // act_ptr already addresses word 0 of this window; the memory
            // samples it at the end of this cycle.
            S_PREF: begin
               op_vld <= 1'b1;
               if (n_words == '0) begin
                  op_code     <= OP_POOL;
                  op_addr     <= '0;
                  op_dat      <= {16'h0, bias_q};
                  op_from_act <= 1'b0;
                  state       <= S_POOL;
               end else begin
                  op_code     <= OP_ACC;
                  op_addr     <= param_base;
                  op_from_act <= 1'b1;
                  hold_vld    <= 1'b0;
                  k_cnt       <= '0;
                  // The pointer never runs past the window's last word, so no
                  // address beyond the group is ever presented.
                  if (n_words != CNT_W'(1)) begin
                     act_ptr <= act_ptr + ADDR_W'(1);
                  end
                  state <= S_ACC;
               end
            end

            S_ACC: begin
               if (bus.bnn_ready) begin
                  hold_vld <= 1'b0;
                  if (k_cnt == n_last) begin
                     k_cnt       <= '0;
                     op_code     <= OP_POOL;
                     op_addr     <= '0;
                     op_dat      <= {16'h0, bias_q};
                     op_from_act <= 1'b0;
                     state       <= S_POOL;
                  end else begin
                     k_cnt   <= k_inc;
                     op_addr <= param_base + ADDR_W'(k_inc);
                     if (k_inc != n_last) begin
                        act_ptr <= act_ptr + ADDR_W'(1);
                     end
                  end
               end else if (!hold_vld) begin
                  hold_dat <= bus.act_rdata;
                  hold_vld <= 1'b1;
               end
            end

            S_POOL: begin
               if (bus.bnn_ready) begin
                  w_cnt <= w_inc;
                  if (w_inc < w_lim) begin
                     op_vld <= 1'b0;
                     // Step from the last word of this window to word 0 of
                     // the next one.
                     if (n_words != '0) begin
                        act_ptr <= act_ptr + ADDR_W'(1);
                     end
                     state <= S_PREF;
                  end else begin
                     op_code <= OP_NORM;
                     op_addr <= norm_addr;
                     op_dat  <= '0;
                     state   <= S_NORM;
                  end
               end
            end

            S_NORM: begin
               if (bus.bnn_ready) begin
                  op_vld    <= 1'b0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end
            end

            // Three cycles cover the unit's two pipeline stages plus its pool
            // register; the result is captured on the way into DONE so it is
            // already valid while done_o is high.
            S_DRAIN: begin
               if (bus.bnn_ready) begin
                  if (drain_cnt == 2'd2) begin
                     result_o <= bus.bnn_result;
                     done_o   <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     drain_cnt <= drain_cnt + 2'd1;
                  end
               end
            end

            S_DONE: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zeroriscy_bnn_seq.sv
// Directed bench for zeroriscy_bnn_seq: drives configurations, models a simple
// estimate unit and activation memory, records the op stream and activation
// address trace, and compares them against hand-derived expectations.
module tb_zeroriscy_bnn_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] in_words;
   logic [15:0] pool_win;
   logic [31:0] param_base;
   logic [31:0] norm_addr;
   logic [31:0] act_base;
   logic [15:0] bias;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   zeroriscy_bnn_seq_if #(.ADDR_W(32)) bus ();

   zeroriscy_bnn_seq #(.CNT_W(16), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .in_words_i   (in_words),
      .pool_win_i   (pool_win),
      .param_base_i (param_base),
      .norm_addr_i  (norm_addr),
      .act_base_i   (act_base),
      .bias_i       (bias),
      .bus          (bus.master),
      .busy_o       (busy),
      .done_o       (done),
      .result_o     (result)
   );

   // Synchronous activation memory
   logic [31:0] act_mem [0:1023];
   always @(posedge clk) bus.act_rdata <= act_mem[bus.act_addr[9:0]];

   // Behavioural estimate unit: acc adds popcount(xnor(data, 0)) - 16,
   // pool shifts in the non-negative flag and reloads the bias.
   logic signed [31:0] m_acc = '0;
   logic [31:0]        m_res = '0;
   assign bus.bnn_result = m_res;

   logic [2:0]  q_code [$];
   logic [31:0] q_addr [$];
   logic [31:0] q_data [$];
   logic [31:0] q_act  [$];
   bit          rec = 1'b0;

   always @(negedge clk) begin
      if (rec && rst_n && bus.bnn_en) begin
         q_code.push_back(bus.bnn_operator);
         q_addr.push_back(bus.bnn_addr);
         q_data.push_back(bus.bnn_data);
         case (bus.bnn_operator)
            3'd0: begin
               m_acc = {{16{bus.bnn_data[15]}}, bus.bnn_data[15:0]};
               m_res = '0;
            end
            3'd1: m_acc = m_acc + 16 - $countones(bus.bnn_data);
            3'd2: begin
               m_res = {m_res[30:0], ~m_acc[31]};
               m_acc = {{16{bus.bnn_data[15]}}, bus.bnn_data[15:0]};
            end
            default: ;
         endcase
      end
      if (rec && busy && (q_act.size() == 0 || q_act[$] != bus.act_addr))
         q_act.push_back(bus.act_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_op(input string pre, input int i, input logic [31:0] code,
                         input logic [31:0] addr, input logic [31:0] data);
      chk($sformatf("%s_op%0d_code", pre, i), (i < q_code.size()) ? 32'(q_code[i]) : 'x, code);
      chk($sformatf("%s_op%0d_addr", pre, i), (i < q_addr.size()) ? q_addr[i] : 'x, addr);
      chk($sformatf("%s_op%0d_data", pre, i), (i < q_data.size()) ? q_data[i] : 'x, data);
   endtask

   task automatic chk_act(input string pre, input int i, input logic [31:0] exp);
      chk($sformatf("%s_act%0d", pre, i), (i < q_act.size()) ? q_act[i] : 'x, exp);
   endtask

   task automatic set_cfg(input logic [15:0] n, input logic [15:0] w, input logic [31:0] pb,
                          input logic [31:0] na, input logic [31:0] ab, input logic [15:0] b);
      in_words = n; pool_win = w; param_base = pb; norm_addr = na; act_base = ab; bias = b;
   endtask

   task automatic load_mem_a();
      act_mem[10'h100] = 32'hFFFF0000;
      act_mem[10'h101] = 32'h0000FFFF;
   endtask

   task automatic load_mem_b();
      for (int i = 0; i < 3; i++) act_mem[10'h100 + i] = 32'h00000000;
      for (int i = 3; i < 6; i++) act_mem[10'h100 + i] = 32'hFFFFFFFF;
   endtask

   // Called at #1 after a posedge. Returns the cycle (INI = cycle 1) in which
   // done was seen, or -1 if it never came within the budget.
   task automatic run(input int stall_cyc, input int stall_len, input int perturb_cyc,
                      output int lat, output logic busy1);
      q_code.delete(); q_addr.delete(); q_data.delete(); q_act.delete();
      rec   = 1'b1;
      lat   = -1;
      busy1 = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         bus.bnn_ready = !(c >= stall_cyc && c < stall_cyc + stall_len);
         if (c == perturb_cyc) begin
            start = 1'b1;
            set_cfg(16'd1, 16'd4, 32'h77, 32'h99, 32'h300, 16'h8000);
         end
         if (c == perturb_cyc + 1) start = 1'b0;
         if (c == 1) busy1 = busy;
         if (done) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      bus.bnn_ready = 1'b1;
      rec = 1'b0;
   endtask

   task automatic chk_stream_a(input string pre);
      chk({pre, "_nops"}, q_code.size(), 5);
      chk_op(pre, 0, 0, 32'h0,  32'h5);
      chk_op(pre, 1, 1, 32'h10, 32'hFFFF0000);
      chk_op(pre, 2, 1, 32'h11, 32'h0000FFFF);
      chk_op(pre, 3, 2, 32'h0,  32'h5);
      chk_op(pre, 4, 3, 32'h40, 32'h0);
      chk({pre, "_nact"}, q_act.size(), 2);
      chk_act(pre, 0, 32'h100);
      chk_act(pre, 1, 32'h101);
   endtask

   task automatic chk_stream_b(input string pre);
      int i;
      chk({pre, "_nops"}, q_code.size(), 10);
      chk_op(pre, 0, 0, 32'h0, 32'h5);
      i = 1;
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < 3; k++) begin
            chk_op(pre, i, 1, 32'h10 + k, (w == 0) ? 32'h0 : 32'hFFFFFFFF);
            i++;
         end
         chk_op(pre, i, 2, 32'h0, 32'h5);
         i++;
      end
      chk_op(pre, 9, 3, 32'h40, 32'h0);
      chk({pre, "_nact"}, q_act.size(), 6);
      for (int a = 0; a < 6; a++) chk_act(pre, a, 32'h100 + a);
   endtask

   task automatic chk_after(input string pre);
      @(posedge clk); #1;
      chk({pre, "_done_pulse"}, done, 1'b0);
      chk({pre, "_busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int   lat;
      logic busy1;

      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int   lat;
      logic busy1;

      rst_n = 1'b0;
      start = 1'b0;
      bus.bnn_ready = 1'b1;
      set_cfg(16'd0, 16'd0, 32'h0, 32'h0, 32'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en",      bus.bnn_en, 1'b0);
      chk("rst_addr",    bus.bnn_addr, 32'h0);
      chk("rst_data",    bus.bnn_data, 32'h0);
      chk("rst_act",     bus.act_addr, 32'h0);
      chk("rst_busy",    busy, 1'b0);
      chk("rst_done",    done, 1'b0);
      chk("rst_result",  result, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // A: N=2, W=1
      set_cfg(16'd2, 16'd1, 32'h10, 32'h40, 32'h100, 16'h0005);
      load_mem_a();
      run(0, 0, 0, lat, busy1);
      chk("a_busy1", busy1, 1'b1);
      chk("a_latency", lat, 10);
      chk("a_result", result, 32'h1);
      chk_stream_a("a");
      chk_after("a");

      // C: same as A with ready low for 4 cycles during the 2nd acc
      run(4, 4, 0, lat, busy1);
      chk("c_latency", lat, 14);
      chk("c_result", result, 32'h1);
      chk_stream_a("c");
      chk_after("c");

      // B: N=3, W=2
      set_cfg(16'd3, 16'd2, 32'h10, 32'h40, 32'h100, 16'h0005);
      load_mem_b();
      run(0, 0, 0, lat, busy1);
      chk("b_latency", lat, 16);
      chk("b_result", result, 32'h2);
      chk_stream_b("b");
      chk_after("b");

      // E: B again, with start re-pulsed and config changed mid-sequence
      run(0, 0, 5, lat, busy1);
      chk("e_latency", lat, 16);
      chk("e_result", result, 32'h2);
      chk_stream_b("e");
      chk_after("e");

      // D: N=0, W=0 (one window, no acc)
      set_cfg(16'd0, 16'd0, 32'h10, 32'h40, 32'h200, 16'h0007);
      run(0, 0, 0, lat, busy1);
      chk("d_latency", lat, 8);
      chk("d_result", result, 32'h1);
      chk("d_nops", q_code.size(), 3);
      chk_op("d", 0, 0, 32'h0,  32'h7);
      chk_op("d", 1, 2, 32'h0,  32'h7);
      chk_op("d", 2, 3, 32'h40, 32'h0);
      chk("d_nact", q_act.size(), 1);
      chk_act("d", 0, 32'h200);
      chk_after("d");

      // F: reset during ACC, then a fresh complete run. Put a nonzero value
      // in result_o first so its clearing is observable.
      set_cfg(16'd3, 16'd2, 32'h10, 32'h40, 32'h100, 16'h0005);
      load_mem_b();
      run(0, 0, 0, lat, busy1);
      chk("f_pre_result", result, 32'h2);
      chk_after("f_pre");
      set_cfg(16'd2, 16'd1, 32'h10, 32'h40, 32'h100, 16'h0005);
      load_mem_a();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("f_acc_en", bus.bnn_en, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("f_rst_en", bus.bnn_en, 1'b0);
      chk("f_rst_busy", busy, 1'b0);
      chk("f_rst_result", result, 32'h0);
      chk("f_rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(0, 0, 0, lat, busy1);
      chk("f_latency", lat, 10);
      chk("f_result", result, 32'h1);
      chk_stream_a("f");
      chk_after("f");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
